debounce_multi: RTL and testbench

//  N-channel button conditioner, successor of the single-channel debouncer. Per channel:
//  2-FF synchroniser, stability-counter debounce, one-cycle rise/fall pulses, and

---
 rtl/debounce_multi_if.sv | 21 ++
 rtl/debounce_multi.sv | 120 ++++++++++++
 tb/tb_debounce_multi.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// Button conditioner bus: raw inputs in, debounced level and event pulses out.
interface debounce_multi_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] rise_out;
    logic [N_CH-1:0] fall_out;
    logic [N_CH-1:0] long_out;
    logic [N_CH-1:0] repeat_out;

    modport master (
        output raw_in,
        input  level_out, rise_out, fall_out, long_out, repeat_out
    );

    modport slave (
        input  raw_in,
        output level_out, rise_out, fall_out, long_out, repeat_out
    );
endinterface

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: 2-FF sync, stability debounce, edge pulses,
// long-press detection with optional auto-repeat. Channels are fully independent.
module debounce_multi #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_TIME   = 100,
    parameter int unsigned LONG_PRESS_TIME = 500,
    parameter int unsigned REPEAT_TIME     = 200,
    parameter logic        INIT_LEVEL      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    debounce_multi_if.slave  bus
);
    localparam int unsigned HMAX = (LONG_PRESS_TIME > REPEAT_TIME) ? LONG_PRESS_TIME : REPEAT_TIME;
    localparam int unsigned DW   = $clog2(DEBOUNCE_TIME + 1);
    localparam int unsigned HW   = $clog2(HMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LONG,
        REPEAT
    } hold_state_e;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic          s1_q, s2_q;
        logic          lvl_q, lvl_d;
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        hold_state_e   st_q, st_d;
        logic          rise_q, rise_d, fall_q, fall_d;
        logic          long_q, long_d, rep_q, rep_d;

        // State and output registers; reset never produces a pulse.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_q   <= INIT_LEVEL;
                s2_q   <= INIT_LEVEL;
                lvl_q  <= INIT_LEVEL;
                dcnt_q <= '0;
                hcnt_q <= '0;
                st_q   <= IDLE;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                long_q <= 1'b0;
                rep_q  <= 1'b0;
            end else begin
                s1_q   <= bus.raw_in[i];
                s2_q   <= s1_q;
                lvl_q  <= lvl_d;
                dcnt_q <= dcnt_d;
                hcnt_q <= hcnt_d;
                st_q   <= st_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
                long_q <= long_d;
                rep_q  <= rep_d;
            end
        end

        // Debounce accept and hold-state next values; an accepted fall overrides the hold FSM.
        always_comb begin
            lvl_d  = lvl_q;
            dcnt_d = dcnt_q;
            hcnt_d = hcnt_q;
            st_d   = st_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            long_d = 1'b0;
            rep_d  = 1'b0;

            if (s2_q == lvl_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DW'(DEBOUNCE_TIME - 1)) begin
                lvl_d  = s2_q;
                dcnt_d = '0;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end

            if (fall_d) begin
                st_d   = IDLE;
                hcnt_d = '0;
            end else if (rise_d) begin
                st_d   = WAIT_LONG;
                hcnt_d = HW'(1);
            end else begin
                case (st_q)
                    WAIT_LONG: begin
                        if (hcnt_q == HW'(LONG_PRESS_TIME)) begin
                            long_d = 1'b1;
                            hcnt_d = HW'(1);
                            st_d   = REPEAT;
                        end else begin
                            hcnt_d = hcnt_q + HW'(1);
                        end
                    end
                    REPEAT: begin
                        if (REPEAT_TIME != 0) begin
                            if (hcnt_q == HW'(REPEAT_TIME)) begin
                                rep_d  = 1'b1;
                                hcnt_d = HW'(1);
                            end else begin
                                hcnt_d = hcnt_q + HW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign bus.level_out[i]  = lvl_q;
        assign bus.rise_out[i]   = rise_q;
        assign bus.fall_out[i]   = fall_q;
        assign bus.long_out[i]   = long_q;
        assign bus.repeat_out[i] = rep_q;
    end
endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: default config (A) plus a no-repeat, DT=1 config (B).
module tb_debounce_multi;
    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;
    int rise_cnt_a [4];
    int rep_cnt_a  [4];
    int long_cnt_b = 0;
    int rep_cnt_b  = 0;

    debounce_multi_if #(.N_CH(4)) bus_a ();
    debounce_multi_if #(.N_CH(2)) bus_b ();

    debounce_multi #(
        .N_CH(4), .DEBOUNCE_TIME(100), .LONG_PRESS_TIME(500),
        .REPEAT_TIME(200), .INIT_LEVEL(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );

    debounce_multi #(
        .N_CH(2), .DEBOUNCE_TIME(1), .LONG_PRESS_TIME(5),
        .REPEAT_TIME(0), .INIT_LEVEL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                rise_cnt_a[c] += int'(bus_a.rise_out[c]);
                rep_cnt_a[c]  += int'(bus_a.repeat_out[c]);
            end
            long_cnt_b += int'(bus_b.long_out[0]);
            rep_cnt_b  += int'(bus_b.repeat_out[0]);
        end
    endtask

    function automatic logic [31:0] all_a();
        return {12'd0, bus_a.level_out, bus_a.rise_out, bus_a.fall_out,
                bus_a.long_out, bus_a.repeat_out};
    endfunction

    initial begin
        for (int c = 0; c < 4; c++) begin
            rise_cnt_a[c] = 0;
            rep_cnt_a[c]  = 0;
        end
        rst          = 1'b0;
        bus_a.raw_in = 4'b0000;
        bus_b.raw_in = 2'b00;

        // Reset state
        tick(2);
        check("reset_outputs_a", all_a(), 32'h0);
        check("reset_level_b", 32'(bus_b.level_out), 32'h0);
        rst = 1'b1;
        tick(3);
        check("post_reset_quiet", all_a(), 32'h0);

        // 1: clean press on ch0
        bus_a.raw_in = 4'b0001;
        tick(101);
        check("t1_level_before", 32'(bus_a.level_out), 32'h0);
        tick(1);
        check("t1_level_at", 32'(bus_a.level_out), 32'h1);
        check("t1_rise_at", 32'(bus_a.rise_out), 32'h1);
        tick(1);
        check("t1_rise_one_cycle", 32'(bus_a.rise_out), 32'h0);
        bus_a.raw_in = 4'b0000;
        tick(101);
        check("t1_level_held", 32'(bus_a.level_out), 32'h1);
        tick(1);
        check("t1_fall_at", 32'(bus_a.fall_out), 32'h1);
        check("t1_level_released", 32'(bus_a.level_out), 32'h0);

        // 2: bounce on ch1, then a 99-cycle glitch
        tick(5);
        bus_a.raw_in = 4'b0010; tick(2);
        bus_a.raw_in = 4'b0000; tick(2);
        bus_a.raw_in = 4'b0010; tick(2);
        bus_a.raw_in = 4'b0000; tick(2);
        bus_a.raw_in = 4'b0010;
        tick(101);
        check("t2_level_before", 32'(bus_a.level_out), 32'h0);
        tick(1);
        check("t2_rise_at", 32'(bus_a.rise_out), 32'h2);
        check("t2_single_rise", 32'(rise_cnt_a[1]), 32'd1);
        bus_a.raw_in = 4'b0000;
        tick(103);
        check("t2_released", 32'(bus_a.level_out), 32'h0);
        bus_a.raw_in = 4'b0010;
        tick(99);
        bus_a.raw_in = 4'b0000;
        tick(110);
        check("t2_glitch_level", 32'(bus_a.level_out), 32'h0);
        check("t2_glitch_no_rise", 32'(rise_cnt_a[1]), 32'd1);

        // 3: long press and auto-repeat on ch2
        bus_a.raw_in = 4'b0100;
        tick(102);
        check("t3_rise", 32'(bus_a.rise_out), 32'h4);
        tick(499);
        check("t3_long_before", 32'(bus_a.long_out), 32'h0);
        tick(1);
        check("t3_long_at", 32'(bus_a.long_out), 32'h4);
        check("t3_no_repeat_at_long", 32'(bus_a.repeat_out), 32'h0);
        for (int r = 0; r < 5; r++) begin
            tick(199);
            check($sformatf("t3_rep%0d_before", r), 32'(bus_a.repeat_out), 32'h0);
            tick(1);
            check($sformatf("t3_rep%0d_at", r), 32'(bus_a.repeat_out), 32'h4);
        end
        bus_a.raw_in = 4'b0000;
        tick(102);
        check("t3_fall", 32'(bus_a.fall_out), 32'h4);
        tick(300);
        check("t3_repeat_total", 32'(rep_cnt_a[2]), 32'd5);
        check("t3_idle_level", 32'(bus_a.level_out), 32'h0);

        // 4: simultaneous press on ch0/ch3, then a short ch3 press
        bus_a.raw_in = 4'b1001;
        tick(101);
        check("t4_rise_before", 32'(bus_a.rise_out), 32'h0);
        tick(1);
        check("t4_rise_both", 32'(bus_a.rise_out), 32'h9);
        bus_a.raw_in = 4'b0000;
        tick(102);
        check("t4_fall_both", 32'(bus_a.fall_out), 32'h9);
        bus_a.raw_in = 4'b1000;
        tick(50);
        bus_a.raw_in = 4'b0000;
        tick(150);
        check("t4_short_no_rise", 32'(rise_cnt_a[3]), 32'd1);
        check("t4_short_level", 32'(bus_a.level_out), 32'h0);

        // 5: reset while ch2 is repeating
        bus_a.raw_in = 4'b0100;
        tick(102);
        check("t5_rise", 32'(bus_a.rise_out), 32'h4);
        tick(500);
        check("t5_long", 32'(bus_a.long_out), 32'h4);
        tick(250);
        rst = 1'b0;
        #1;
        check("t5_async_clear", all_a(), 32'h0);
        tick(3);
        check("t5_held_clear", all_a(), 32'h0);
        rst = 1'b1;
        tick(101);
        check("t5_level_before", 32'(bus_a.level_out), 32'h0);
        tick(1);
        check("t5_rise_again", 32'(bus_a.rise_out), 32'h4);
        tick(499);
        check("t5_long_before", 32'(bus_a.long_out), 32'h0);
        tick(1);
        check("t5_long_restart", 32'(bus_a.long_out), 32'h4);
        bus_a.raw_in = 4'b0000;
        tick(102);
        check("t5_fall", 32'(bus_a.fall_out), 32'h4);

        // 6: DT=1, repeat disabled
        bus_b.raw_in = 2'b01;
        tick(2);
        check("t6_level_before", 32'(bus_b.level_out), 32'h0);
        tick(1);
        check("t6_level_at", 32'(bus_b.level_out), 32'h1);
        check("t6_rise_at", 32'(bus_b.rise_out), 32'h1);
        tick(4);
        check("t6_long_before", 32'(bus_b.long_out), 32'h0);
        tick(1);
        check("t6_long_at", 32'(bus_b.long_out), 32'h1);
        tick(50);
        check("t6_single_long", 32'(long_cnt_b), 32'd1);
        check("t6_no_repeat", 32'(rep_cnt_b), 32'd0);
        bus_b.raw_in = 2'b00;
        tick(2);
        check("t6_fall_before", 32'(bus_b.level_out), 32'h1);
        tick(1);
        check("t6_fall_at", 32'(bus_b.fall_out), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
